// File: rtl/muldiv_pkg.sv
// Shared types and op codes for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP,
      DONE
   } state_t;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step on {acc, lo}: shift-add multiply or restoring divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            div_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] part;
   logic [XLEN:0] diff;

   always_comb begin
      sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, d_i} : {(XLEN+1){1'b0}});
      part = {acc_i, lo_i[XLEN-1]};
      diff = part - {1'b0, d_i};
      acc_o = sum[XLEN:1];
      lo_o  = {sum[0], lo_i[XLEN-1:1]};
      if (div_i) begin
         // partial remainder stays below the divisor, so XLEN bits suffice
         if (diff[XLEN]) begin
            acc_o = part[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o = diff[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension execute unit with stall/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL*.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       funct3_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] rd_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] rd_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [TAG_W-1:0]  rdo_q, rdo_d;

   logic              div_in, sgn_a, sgn_b, sa, sb, ovf;
   logic [XLEN-1:0]   a_mag, b_mag, step_acc, step_lo, fix_res;
   logic [2*XLEN-1:0] full, fneg;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] prod_fast;
   assign prod_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

   always_comb begin
      div_in = is_div(funct3_i);
      sgn_b  = (funct3_i == MD_MULH) || (funct3_i == MD_DIV) ||
               (funct3_i == MD_REM);
      sgn_a  = sgn_b || (funct3_i == MD_MULHSU);
      sa     = sgn_a & a_i[XLEN-1];
      sb     = sgn_b & b_i[XLEN-1];
      a_mag  = sa ? -a_i : a_i;
      b_mag  = sb ? -b_i : b_i;
      ovf    = ((funct3_i == MD_DIV) || (funct3_i == MD_REM)) &&
               (a_i == SMIN) && (&b_i);
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i (is_div(op_q)),
      .acc_i (acc_q),
      .lo_i  (lo_q),
      .d_i   (opd_q),
      .acc_o (step_acc),
      .lo_o  (step_lo)
   );

   always_comb begin
      full = is_div(op_q) ?
             {{XLEN{1'b0}}, (op_q[1] ? acc_q : lo_q)} : {acc_q, lo_q};
      fneg = neg_q ? -full : full;
      fix_res = (!is_div(op_q) && op_q != MD_MUL) ?
                fneg[2*XLEN-1:XLEN] : fneg[XLEN-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opd_d   = opd_q;
      op_d    = op_q;
      neg_d   = neg_q;
      tag_d   = tag_q;
      res_d   = res_q;
      rdo_d   = rdo_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall_o = start_i & reset;
            if (start_i && !flush_i) begin
               op_d  = funct3_i;
               tag_d = rd_i;
               cnt_d = '0;
               acc_d = '0;
               opd_d = div_in ? b_mag : a_mag;
               lo_d  = div_in ? a_mag : b_mag;
               // remainder sign follows the dividend only
               neg_d = (div_in && funct3_i[1]) ? sa : (sa ^ sb);
               if (div_in && b_i == '0) begin
                  state_d = DONE;
                  res_d   = funct3_i[1] ? a_i : '1;
                  rdo_d   = rd_i;
               end else if (ovf) begin
                  state_d = DONE;
                  res_d   = funct3_i[1] ? '0 : a_i;
                  rdo_d   = rd_i;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!div_in) begin
                  state_d = FIXUP;
                  acc_d   = prod_fast[2*XLEN-1:XLEN];
                  lo_d    = prod_fast[XLEN-1:0];
               end
`endif
               else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            stall_o = 1'b1;
            acc_d   = step_acc;
            lo_d    = step_lo;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
               state_d = FIXUP;
               cnt_d   = '0;
            end
         end
         FIXUP: begin
            stall_o = 1'b1;
            res_d   = fix_res;
            rdo_d   = tag_q;
            state_d = DONE;
         end
         DONE: begin
            done_o  = ~flush_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         res_d   = res_q;
         rdo_d   = rdo_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opd_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         tag_q   <= '0;
         res_q   <= '0;
         rdo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opd_q   <= opd_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         rdo_q   <= rdo_d;
      end
   end

   assign result_o = res_q;
   assign rd_o     = rdo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int checks = 0;
   int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .rd_i     (rd_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output logic acc_stall);
      @(posedge clk); #1;
      start_i = 1'b1; funct3_i = f; a_i = a; b_i = b; rd_i = rd;
      #1 acc_stall = stall_o;
      lat = 0;
      do begin
         @(posedge clk); #1;
         start_i = 1'b0;
         lat++;
      end while (done_o !== 1'b1 && lat < 100);
      res = result_o;
      rdo = rd_o;
   endtask

   task automatic test_reset();
      reset = 1'b0; start_i = 1'b0; funct3_i = '0; a_i = '0; b_i = '0;
      rd_i = '0; flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (stall_o !== 1'b0) begin failures++;
         $display("FAIL reset_stall got=%b exp=0", stall_o); end
      checks++; if (done_o !== 1'b0) begin failures++;
         $display("FAIL reset_done got=%b exp=0", done_o); end
      checks++; if (result_o !== 32'h0) begin failures++;
         $display("FAIL reset_result got=%h exp=0", result_o); end
      checks++; if (rd_o !== 5'd0) begin failures++;
         $display("FAIL reset_rd got=%0d exp=0", rd_o); end
      reset = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] r; logic [4:0] t; int lat; logic st;
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, r, t, lat, st);
      checks++; if (st !== 1'b1) begin failures++;
         $display("FAIL mul_accept_stall got=%b exp=1", st); end
      checks++; if (r !== 32'hFFFFFFEB) begin failures++;
         $display("FAIL mul_result got=%h exp=ffffffeb", r); end
      checks++; if (t !== 5'd5) begin failures++;
         $display("FAIL mul_rd got=%0d exp=5", t); end
      checks++; if (lat != MUL_LAT) begin failures++;
         $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
      @(posedge clk); #1;
      checks++; if (done_o !== 1'b0 || result_o !== 32'hFFFFFFEB) begin
         failures++;
         $display("FAIL mul_pulse_hold got=%b/%h exp=0/ffffffeb",
                  done_o, result_o); end
   endtask

   task automatic test_mulh();
      logic [31:0] r; logic [4:0] t; int lat; logic st;
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, t, lat, st);
      checks++; if (r !== 32'hFFFFFFFE) begin failures++;
         $display("FAIL mulhu got=%h exp=fffffffe", r); end
      run_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd2, r, t, lat, st);
      checks++; if (r !== 32'hFFFFFFFF) begin failures++;
         $display("FAIL mulhsu got=%h exp=ffffffff", r); end
      checks++; if (lat != MUL_LAT) begin failures++;
         $display("FAIL mulhsu_latency got=%0d exp=%0d", lat, MUL_LAT); end
      run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, r, t, lat, st);
      checks++; if (r !== 32'h0) begin failures++;
         $display("FAIL mulh got=%h exp=00000000", r); end
   endtask

   task automatic test_div();
      logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
      logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] e [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
      logic [31:0] r; logic [4:0] t; int lat; logic st;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], 5'(i + 8), r, t, lat, st);
         checks++; if (r !== e[i]) begin failures++;
            $display("FAIL div_result[%0d] got=%h exp=%h", i, r, e[i]); end
         checks++; if (lat != 34 || t !== 5'(i + 8)) begin failures++;
            $display("FAIL div_lat_rd[%0d] got=%0d/%0d exp=34/%0d",
                     i, lat, t, i + 8); end
      end
   endtask

   task automatic test_early_out();
      logic [2:0]  f [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] e [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      logic [31:0] r; logic [4:0] t; int lat; logic st;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], 5'(i + 20), r, t, lat, st);
         checks++; if (r !== e[i]) begin failures++;
            $display("FAIL early_result[%0d] got=%h exp=%h", i, r, e[i]); end
         checks++; if (lat != 1 || t !== 5'(i + 20)) begin failures++;
            $display("FAIL early_lat_rd[%0d] got=%0d/%0d exp=1/%0d",
                     i, lat, t, i + 20); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] r; logic [4:0] t; int lat; logic st;
      int dones = 0;
      @(posedge clk); #1;
      start_i = 1'b1; funct3_i = 3'b101; a_i = 32'd1000; b_i = 32'd3;
      rd_i = 5'd9;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (done_o === 1'b1) dones++;
      end
      checks++; if (stall_o !== 1'b1) begin failures++;
         $display("FAIL flush_pre_stall got=%b exp=1", stall_o); end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      if (done_o === 1'b1) dones++;
      checks++; if (stall_o !== 1'b0) begin failures++;
         $display("FAIL flush_stall got=%b exp=0", stall_o); end
      checks++; if (dones != 0 || result_o !== 32'd0) begin failures++;
         $display("FAIL flush_no_done got=%0d/%h exp=0/00000000",
                  dones, result_o); end
      run_op(3'b101, 32'd100, 32'd7, 5'd11, r, t, lat, st);
      checks++; if (r !== 32'd14 || lat != 34 || t !== 5'd11) begin
         failures++;
         $display("FAIL flush_next_op got=%h/%0d/%0d exp=0000000e/34/11",
                  r, lat, t); end
   endtask

   task automatic test_reset_mid_op();
      int dones = 0;
      @(posedge clk); #1;
      start_i = 1'b1; funct3_i = 3'b100; a_i = 32'hFFFFFFF9; b_i = 32'd2;
      rd_i = 5'd17;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b0 || done_o !== 1'b0) begin failures++;
         $display("FAIL rst_mid_ctrl got=%b/%b exp=0/0", stall_o, done_o); end
      checks++; if (result_o !== 32'd0 || rd_o !== 5'd0) begin failures++;
         $display("FAIL rst_mid_out got=%h/%0d exp=0/0", result_o, rd_o); end
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) dones++;
      end
      start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) dones++;
      end
      checks++; if (dones != 1) begin failures++;
         $display("FAIL held_start_dones got=%0d exp=1", dones); end
      checks++; if (result_o !== 32'hFFFFFFFD || rd_o !== 5'd17) begin
         failures++;
         $display("FAIL held_start_result got=%h/%0d exp=fffffffd/17",
                  result_o, rd_o); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_early_out();
      test_flush();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
